tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
Melody sequencer that drives the note-select and enable inputs of the on-board audio PWM stage. Steps through a small writable pattern memory of note/duration entries. For each entry it asserts `sel`/`en` for a programmed duration, then inserts a short silent gap. It handles start/stop/loop control from the top-level game/UI logic.

Parameters:
- `UNIT_CYCLES`, 5_000_000: clk cycles per duration unit (50 ms at 100 MHz); must be ≥1.
- `GAP_CYCLES`, 500_000: silent clk cycles between entries (5 ms); 0 means no gap.
- `DEPTH`, 16: pattern memory entries, power of 2, ≥2.
- `AW`, 4: address width, equal to log2(DEPTH).

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `start`  in  1  level-sampled; begins playback from entry 0 when idle.
- `stop`  in  1  aborts playback.
- `loop`  in  1  when 1, playback restarts at entry 0 after the last entry.
- `wr_en`  in  1  pattern memory write strobe.
- `wr_addr`  in  AW  write address.
- `wr_data`  in  8  entry format:
  - [7] rest
  - [6:4] note select
  - [3:0] duration units; 0 = end-of-song marker.
- `sel`  out  3  note select to audio stage.
- `en`  out  1  tone enable to audio stage.
- `busy`  out  1  high in PLAY or GAP.
- `done`  out  1  one-cycle pulse on natural end of song.
- `idx`  out  AW  index of the current entry.

Behaviour:
- Reset (`rst`=0, async):
  - `sel`=0, `en`=0, `busy`=0, `done`=0, `idx`=0, state=IDLE, timers cleared.
  - Pattern memory is not reset.
- States: IDLE, PLAY, GAP.
- Fetch (combinational read of `mem[next_idx]`, registered on the transition edge):
  - Latches `cur_rest`, `cur_note`, `cur_dur` and sets `idx`.
  - If the fetched duration is 0 → end handling instead of PLAY.
- End handling:
  - `loop`=1 → fetch entry 0.
  - `loop`=0 → IDLE with `done`=1 for exactly one cycle.
  - If entry 0 itself has duration 0, end handling always goes to IDLE with `done`, even when `loop`=1 (prevents a zero-length livelock).
- IDLE:
  - `start`=1 at edge k → fetch entry 0 at edge k.
  - `sel`=note, `en`=~rest, `busy`=1 are visible after edge k (1-cycle latency).
- PLAY:
  - Lasts exactly `cur_dur`×`UNIT_CYCLES` cycles.
  - `en`=~`cur_rest`, `sel`=`cur_note`.
  - Then → GAP, or directly to next-entry handling if `GAP_CYCLES`=0.
- GAP:
  - `en`=0, `sel` holds the last note, lasts exactly `GAP_CYCLES` cycles.
  - Then next-entry handling.
- Next-entry handling:
  - `idx`=DEPTH-1 → end handling (no wrap-around into entry 0 unless `loop`=1).
  - Otherwise fetch `idx`+1.
- `stop`=1 in PLAY/GAP:
  - Next edge → IDLE, `en`=0, `busy`=0, `idx`=0, no `done` pulse.
  - `stop` and `start` together in IDLE → stay IDLE (`stop` wins).
- `start` while busy is ignored; `start` held high after `done` restarts playback on the following cycle.
- `loop` is sampled only at end handling.
- Writes:
  - Accepted in any state and take effect at the next fetch of that address.
  - Overwriting the currently playing entry does not alter the latched note or duration.
  - A write and a fetch of the same address on the same edge returns the old data.
- Counters:
  - Unit counter width is clog2(`UNIT_CYCLES`); duration counter is 4 bits.
  - Neither counter may wrap while active.

Decomposition:
- Shared package `audio_pkg` holds:
  - state encoding enum;
  - entry field localparams (REST_BIT=7, NOTE_MSB=6, NOTE_LSB=4, DUR_MSB=3, DUR_LSB=0);
  - note-select constants matching the audio stage's mux ordering.
- One sub-module: `seq_unit_timer`.
  - Loadable down-counter.
  - Emits a one-cycle expiry strobe after N×`UNIT_CYCLES` or `GAP_CYCLES` cycles.
  - Reused for both PLAY and GAP timing.

Test Plan:
All scenarios use `UNIT_CYCLES`=4, `GAP_CYCLES`=2, `DEPTH`=4.
1. Basic sequence:
   - Stimulus: write {0,3'd5,4'd2}, {1,3'd1,4'd1}, {0,3'd7,4'd1}, {0,0,4'd0}; pulse `start`.
   - Required: `sel`=5 with `en`=1 for 8 cycles, `en`=0 for 2, then `en`=0 (rest) for 4, gap 2, then `sel`=7 with `en`=1 for 4, gap 2, then `done` pulse, IDLE.
2. Full memory with `loop`=1:
   - Stimulus: all 4 entries have duration 1, `loop`=1.
   - Required: after `idx`=3 the gap is followed by `idx`=0 and playback continues. Set `loop`=0 → `done` after the next `idx`=3 entry.
3. Empty song:
   - Stimulus: entry 0 = 8'h00, `loop`=1, `start`.
   - Required: `en` is never 1, `done` pulse one cycle after `start`, `busy` stays 0.
4. Abort:
   - Stimulus: `stop` asserted during PLAY, then again during GAP.
   - Required: `en`=0 and `busy`=0 on the next cycle, `idx`=0, no `done` pulse. `start`+`stop` together in IDLE → remains IDLE.
5. Write during playback:
   - Stimulus: overwrite the playing `idx` while in PLAY.
   - Required: the current note and duration are unchanged; the new value plays on the next loop pass.
6. Reset mid-PLAY:
   - Stimulus: `rst`=0 asynchronously between clock edges.
   - Required: `en`, `busy`, `sel`, `idx` go to 0 immediately. Memory contents are retained, and a replay after reset matches scenario 1.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the melody sequencer: FSM encoding, pattern entry
// field positions and the audio stage's note-select ordering.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_t;

  localparam int REST_BIT = 7;
  localparam int NOTE_MSB = 6;
  localparam int NOTE_LSB = 4;
  localparam int DUR_MSB  = 3;
  localparam int DUR_LSB  = 0;

  // Mux ordering of the audio PWM stage, lowest pitch first.
  localparam logic [2:0] NOTE_C    = 3'd0;
  localparam logic [2:0] NOTE_D    = 3'd1;
  localparam logic [2:0] NOTE_E    = 3'd2;
  localparam logic [2:0] NOTE_F    = 3'd3;
  localparam logic [2:0] NOTE_G    = 3'd4;
  localparam logic [2:0] NOTE_A    = 3'd5;
  localparam logic [2:0] NOTE_B    = 3'd6;
  localparam logic [2:0] NOTE_C_HI = 3'd7;

  function automatic logic [3:0] entry_dur(input logic [7:0] e);
    return e[DUR_MSB:DUR_LSB];
  endfunction

  function automatic logic [2:0] entry_note(input logic [7:0] e);
    return e[NOTE_MSB:NOTE_LSB];
  endfunction

endpackage

// File: rtl/seq_unit_timer.sv
// Loadable down-counter timing either N duration units or one silent gap;
// expire is high during the final cycle of the loaded interval.
module seq_unit_timer #(
  parameter int UNIT_CYCLES = 5_000_000,
  parameter int GAP_CYCLES  = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       clear,
  input  logic       gap_sel,
  input  logic [3:0] load_units,
  output logic       expire
);

  localparam int UW = $clog2(UNIT_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES);
  localparam int CW = (UW > GW) ? ((UW > 1) ? UW : 1) : ((GW > 1) ? GW : 1);
  localparam logic [CW-1:0] UNIT_M1 = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_M1  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  logic [CW-1:0] cnt;
  logic [3:0]    units;
  logic          active;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      units  <= '0;
      active <= 1'b0;
    end else if (load) begin
      active <= 1'b1;
      cnt    <= gap_sel ? GAP_M1 : UNIT_M1;
      units  <= gap_sel ? 4'd0 : load_units - 4'd1;
    end else if (clear) begin
      active <= 1'b0;
      cnt    <= '0;
      units  <= '0;
    end else if (active) begin
      // Both counters stop at zero, so neither can wrap while active.
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else if (units != 4'd0) begin
        units <= units - 4'd1;
        cnt   <= UNIT_M1;
      end else begin
        active <= 1'b0;
      end
    end
  end

  assign expire = active && (cnt == '0) && (units == 4'd0);

endmodule

// File: rtl/tone_sequencer.sv
// Melody sequencer: walks a writable note/duration pattern memory and drives
// the audio stage's sel/en with a silent gap between entries.
module tone_sequencer
  import audio_pkg::*;
#(
  parameter int UNIT_CYCLES = 5_000_000,
  parameter int GAP_CYCLES  = 500_000,
  parameter int DEPTH       = 16,
  parameter int AW          = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic [2:0]    sel,
  output logic          en,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] idx,
  output logic [1:0]    dbg_state
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam bit HAS_GAP = (GAP_CYCLES != 0);

  seq_state_t    state;
  logic [7:0]    mem [DEPTH];
  logic          expire;
  logic          adv, fetch_req, end_req, play_req, idle_done, enter_gap, abort;
  logic [AW-1:0] fetch_addr, play_addr;
  logic [7:0]    fetch_entry, play_entry;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Fetch reads the array before the edge, so a same-edge write yields old data.
  always_comb begin
    adv        = 1'b0;
    fetch_req  = 1'b0;
    end_req    = 1'b0;
    play_req   = 1'b0;
    fetch_addr = '0;
    case (state)
      ST_IDLE: fetch_req = start && !stop;
      ST_PLAY: adv = !stop && expire && !HAS_GAP;
      ST_GAP:  adv = !stop && expire;
      default: ;
    endcase
    if (adv) begin
      if (idx == LAST_IDX) begin
        end_req = 1'b1;
      end else begin
        fetch_req  = 1'b1;
        fetch_addr = idx + 1'b1;
      end
    end
    fetch_entry = mem[fetch_addr];
    play_entry  = fetch_entry;
    play_addr   = fetch_addr;
    if (fetch_req && entry_dur(fetch_entry) == 4'd0) end_req = 1'b1;
    if (fetch_req && entry_dur(fetch_entry) != 4'd0) begin
      play_req = 1'b1;
    end else if (end_req && loop && entry_dur(mem[0]) != 4'd0) begin
      play_req   = 1'b1;
      play_entry = mem[0];
      play_addr  = '0;
    end
    idle_done = end_req && !play_req;
    enter_gap = (state == ST_PLAY) && !stop && expire && HAS_GAP;
    abort     = (state != ST_IDLE) && stop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      sel   <= NOTE_C;
      en    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      idx   <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        sel   <= NOTE_C;
        en    <= 1'b0;
        busy  <= 1'b0;
        idx   <= '0;
      end else if (play_req) begin
        state <= ST_PLAY;
        sel   <= entry_note(play_entry);
        en    <= ~play_entry[REST_BIT];
        busy  <= 1'b1;
        idx   <= play_addr;
      end else if (idle_done) begin
        state <= ST_IDLE;
        sel   <= NOTE_C;
        en    <= 1'b0;
        busy  <= 1'b0;
        done  <= 1'b1;
        idx   <= '0;
      end else if (enter_gap) begin
        state <= ST_GAP;
        en    <= 1'b0;
      end
    end
  end

  seq_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (play_req || enter_gap),
    .clear     (abort || idle_done),
    .gap_sel   (enter_gap),
    .load_units(entry_dur(play_entry)),
    .expire    (expire)
  );

  assign dbg_state = state;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: control vector table, hand-written
// corner sequences, and random songs compared against a song-expansion model.
module tb_tone_sequencer;
  import audio_pkg::*;

  localparam int U  = 4;
  localparam int G  = 2;
  localparam int D  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0, stop = 1'b0, loop = 1'b0, wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic [2:0]    sel;
  logic          en, busy, done;
  logic [AW-1:0] idx;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] img [D];
  logic [7:0] exp_q[$];

  typedef struct {
    logic       start_v;
    logic       stop_v;
    logic       loop_v;
    logic [7:0] mem0;
    logic [7:0] exp_v;
  } vec_t;
  vec_t vecs[7];

  tone_sequencer #(.UNIT_CYCLES(U), .GAP_CYCLES(G), .DEPTH(D), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sel(sel), .en(en), .busy(busy), .done(done), .idx(idx),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Observation packing: {sel, en, busy, done, idx}
  function automatic logic [7:0] obs(input logic [2:0] s, input logic e, input logic b,
                                     input logic dn, input logic [AW-1:0] i);
    return {s, e, b, dn, i};
  endfunction

  task automatic check(input string name, input logic [7:0] exp_v);
    logic [7:0] act;
    act = {sel, en, busy, done, idx};
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got sel=%0d en=%0b busy=%0b done=%0b idx=%0d, want sel=%0d en=%0b busy=%0b done=%0b idx=%0d",
               name, act[7:5], act[4], act[3], act[2], act[1:0],
               exp_v[7:5], exp_v[4], exp_v[3], exp_v[2], exp_v[1:0]);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp_v);
    end
  endtask

  task automatic write_mem(input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; img[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_song1();
    write_mem(0, 8'h52);
    write_mem(1, 8'h91);
    write_mem(2, 8'h71);
    write_mem(3, 8'h00);
  endtask

  // Expand the memory image into the per-cycle output trace after start.
  task automatic build_expect(input int n, input bit lp);
    int a, d;
    bit fin;
    logic [7:0] e;
    exp_q.delete();
    a = 0; fin = 1'b0;
    while (exp_q.size() < n && !fin) begin
      e = img[a];
      d = int'(e[3:0]);
      if (d != 0) begin
        for (int c = 0; c < d * U; c++) exp_q.push_back(obs(e[6:4], ~e[7], 1'b1, 1'b0, AW'(a)));
        for (int c = 0; c < G; c++) exp_q.push_back(obs(e[6:4], 1'b0, 1'b1, 1'b0, AW'(a)));
        if (a != D - 1) begin
          a++;
          continue;
        end
      end
      if (lp && img[0][3:0] != 4'd0) a = 0;
      else fin = 1'b1;
    end
    if (fin) exp_q.push_back(obs(3'd0, 1'b0, 1'b0, 1'b1, '0));
    while (exp_q.size() < n) exp_q.push_back(obs(3'd0, 1'b0, 1'b0, 1'b0, '0));
  endtask

  task automatic run_song(input string name, input int n, input bit lp);
    build_expect(n, lp);
    loop = lp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      check(name, exp_q[i]);
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check({name, "_stop"}, obs(3'd0, 1'b0, 1'b0, 1'b0, '0));
    loop = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int done_at, done_cnt;
    logic r; logic [2:0] nt; logic [3:0] du; bit lp;

    repeat (2) @(negedge clk);
    check("reset_outputs", obs(3'd0, 1'b0, 1'b0, 1'b0, '0));
    check_val("reset_state", int'(dbg_state), 0);
    rst = 1'b1;
    @(negedge clk);

    // Single-cycle control vectors from IDLE
    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h52, obs(3'd0, 1'b0, 1'b0, 1'b0, '0)};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h52, obs(3'd0, 1'b0, 1'b0, 1'b0, '0)};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h52, obs(3'd5, 1'b1, 1'b1, 1'b0, '0)};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 8'hA3, obs(3'd2, 1'b0, 1'b1, 1'b0, '0)};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 8'h00, obs(3'd0, 1'b0, 1'b0, 1'b1, '0)};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h70, obs(3'd0, 1'b0, 1'b0, 1'b1, '0)};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 8'hF1, obs(3'd7, 1'b0, 1'b1, 1'b0, '0)};
    for (int v = 0; v < 7; v++) begin
      write_mem(0, vecs[v].mem0);
      loop = vecs[v].loop_v; start = vecs[v].start_v; stop = vecs[v].stop_v;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      check($sformatf("vec%0d", v), vecs[v].exp_v);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check($sformatf("vec%0d_after", v), obs(3'd0, 1'b0, 1'b0, 1'b0, '0));
      loop = 1'b0;
    end

    // Basic sequence
    load_song1();
    run_song("song1", 30, 1'b0);

    // Full memory with loop, then loop dropped mid second pass
    write_mem(0, 8'h11); write_mem(1, 8'h21); write_mem(2, 8'h31); write_mem(3, 8'h41);
    loop = 1'b1;
    pulse_start();
    done_at = -1; done_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      if (c == 23) check("loop_last_gap", obs(3'd4, 1'b0, 1'b1, 1'b0, 2'd3));
      if (c == 24) check("loop_wrap", obs(3'd1, 1'b1, 1'b1, 1'b0, 2'd0));
      if (c == 25) loop = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      @(negedge clk);
    end
    check_val("loop_done_cycle", done_at, 48);
    check_val("loop_done_count", done_cnt, 1);

    // Abort during PLAY, then during GAP
    load_song1();
    pulse_start();
    repeat (3) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("abort_play", obs(3'd0, 1'b0, 1'b0, 1'b0, '0));
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check_val("abort_no_done", done_cnt, 0);
    pulse_start();
    repeat (8) @(negedge clk);
    check("pre_abort_gap", obs(3'd5, 1'b0, 1'b1, 1'b0, '0));
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("abort_gap", obs(3'd0, 1'b0, 1'b0, 1'b0, '0));

    // Writes during playback, including a same-edge write/fetch of entry 0
    write_mem(0, 8'h52); write_mem(1, 8'h00);
    loop = 1'b1;
    pulse_start();
    for (int c = 0; c < 40; c++) begin
      if (c == 7)  check("wr_old_play", obs(3'd5, 1'b1, 1'b1, 1'b0, '0));
      if (c == 8)  check("wr_old_dur", obs(3'd5, 1'b0, 1'b1, 1'b0, '0));
      if (c == 10) check("wr_new_start", obs(3'd6, 1'b1, 1'b1, 1'b0, '0));
      if (c == 21) check("wr_new_end", obs(3'd6, 1'b1, 1'b1, 1'b0, '0));
      if (c == 22) check("wr_new_gap", obs(3'd6, 1'b0, 1'b1, 1'b0, '0));
      if (c == 24) check("wr_same_edge_old", obs(3'd6, 1'b1, 1'b1, 1'b0, '0));
      if (c == 38) check("wr_second_new", obs(3'd1, 1'b1, 1'b1, 1'b0, '0));
      wr_en = (c == 2) || (c == 23);
      wr_addr = '0;
      wr_data = (c == 2) ? 8'h63 : 8'h11;
      @(negedge clk);
    end
    wr_en = 1'b0; img[0] = 8'h11;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; loop = 1'b0;

    // Asynchronous reset mid-PLAY, then replay
    load_song1();
    pulse_start();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("async_reset", obs(3'd0, 1'b0, 1'b0, 1'b0, '0));
    check_val("async_reset_state", int'(dbg_state), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_song("replay", 30, 1'b0);

    // Random songs against the expansion model
    for (int it = 0; it < 8; it++) begin
      for (int a = 0; a < D; a++) begin
        r  = 1'($urandom_range(0, 1));
        nt = 3'($urandom_range(0, 7));
        du = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
        write_mem(a, {r, nt, du});
      end
      lp = 1'($urandom_range(0, 1));
      run_song($sformatf("rand%0d", it), 80, lp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
